// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared MIPS decode/execute widths, opcode/funct codes, ALU op encoding and control bundle.
package decode_stage_pkg;
    localparam int NB_DATA     = 32;
    localparam int NB_REGISTER = 5;
    localparam int NB_ALU_OP   = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [NB_ALU_OP-1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS
    } alu_op_t;

    typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_t;

    typedef struct packed {
        logic    valid;
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    reads_rt;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    jump_reg;
        logic    link;
        logic    link31;
        ext_t    ext;
    } ctrl_t;
endpackage

// File: rtl/decode_stage_control_unit.sv
// control_unit: opcode/funct to control bundle; jumps (J, JAL, JR, JALR) decode only with MIPS_JUMP_EN,
// otherwise they fall into the invalid (bubble) case.
module control_unit
    import decode_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        ctrl.valid = 1'b1;
        ctrl.reads_rt = opcode == OP_RTYPE || opcode == OP_SW || opcode == OP_BEQ || opcode == OP_BNE;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst = 1'b1;
                case (funct)
                    FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLL:  ctrl.alu_op = ALU_SLL;
                    FN_SRL:  ctrl.alu_op = ALU_SRL;
                    FN_SRA:  ctrl.alu_op = ALU_SRA;
`ifdef MIPS_JUMP_EN
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        {ctrl.jump, ctrl.jump_reg} = 2'b11;
                    end
                    FN_JALR: begin
                        {ctrl.jump, ctrl.jump_reg, ctrl.link, ctrl.alu_src} = 4'b1111;
                        ctrl.alu_op = ALU_PASS;
                    end
`endif
                    default: ctrl.valid = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: {ctrl.alu_src, ctrl.reg_write} = 2'b11;
            OP_SLTI: begin
                {ctrl.alu_src, ctrl.reg_write} = 2'b11;
                ctrl.alu_op = ALU_SLT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                {ctrl.alu_src, ctrl.reg_write} = 2'b11;
                ctrl.ext = EXT_ZERO;
                ctrl.alu_op = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_XOR;
            end
            OP_LUI: begin
                {ctrl.alu_src, ctrl.reg_write} = 2'b11;
                ctrl.ext = EXT_LUI;
                ctrl.alu_op = ALU_LUI;
            end
            OP_LW: {ctrl.alu_src, ctrl.reg_write, ctrl.mem_read, ctrl.mem_to_reg} = 4'b1111;
            OP_SW: {ctrl.alu_src, ctrl.mem_write} = 2'b11;
            OP_BEQ: ctrl.branch = 1'b1;
            OP_BNE: {ctrl.branch, ctrl.branch_ne} = 2'b11;
`ifdef MIPS_JUMP_EN
            OP_J: ctrl.jump = 1'b1;
            OP_JAL: begin
                {ctrl.jump, ctrl.link, ctrl.link31, ctrl.reg_write, ctrl.alu_src} = 5'b11111;
                ctrl.alu_op = ALU_PASS;
            end
`endif
            default: ctrl.valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with WB bypass, load-use stall, branch/jump resolution and ID/EX register.
// Jump decode is enabled by MIPS_JUMP_EN inside control_unit.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_DATA-1:0]     i_instruction,
    input  logic [NB_DATA-1:0]     i_pc_plus_4,
    input  logic                   i_flush,
    input  logic                   i_ex_mem_read,
    input  logic [NB_REGISTER-1:0] i_ex_rt,
    input  logic                   i_wb_reg_write,
    input  logic [NB_REGISTER-1:0] i_wb_write_sel,
    input  logic [NB_DATA-1:0]     i_wb_write_data,
    output logic [NB_REGISTER-1:0] o_read_reg_sel_0,
    output logic [NB_REGISTER-1:0] o_read_reg_sel_1,
    input  logic [NB_DATA-1:0]     i_data_read_reg_0,
    input  logic [NB_DATA-1:0]     i_data_read_reg_1,
    output logic                   o_stall,
    output logic                   o_pc_source,
    output logic [NB_DATA-1:0]     o_pc_next,
    output logic [NB_DATA-1:0]     o_rs_data,
    output logic [NB_DATA-1:0]     o_rt_data,
    output logic [NB_DATA-1:0]     o_imm_ext,
    output logic [NB_REGISTER-1:0] o_rs,
    output logic [NB_REGISTER-1:0] o_rt,
    output logic [NB_REGISTER-1:0] o_rd_dest,
    output logic [NB_REGISTER-1:0] o_shamt,
    output logic [NB_ALU_OP-1:0]   o_alu_op,
    output logic                   o_alu_src,
    output logic                   o_mem_read,
    output logic                   o_mem_write,
    output logic                   o_reg_write,
    output logic                   o_mem_to_reg
);
    ctrl_t                  ctrl;
    logic [NB_REGISTER-1:0] rs, rt, rd, dest;
    logic [15:0]            imm;
    logic [NB_DATA-1:0]     rs_val, rt_val, imm_ext, branch_target;
    logic                   capture;

    control_unit u_control_unit (
        .opcode(i_instruction[31:26]),
        .funct (i_instruction[5:0]),
        .ctrl  (ctrl)
    );

    assign rs = i_instruction[25:21];
    assign rt = i_instruction[20:16];
    assign rd = i_instruction[15:11];
    assign imm = i_instruction[15:0];
    assign o_read_reg_sel_0 = rs;
    assign o_read_reg_sel_1 = rt;

    // r0 is hard zero, which also makes a WB write to r0 invisible
    assign rs_val = rs == '0 ? '0 : (i_wb_reg_write && i_wb_write_sel == rs) ? i_wb_write_data : i_data_read_reg_0;
    assign rt_val = rt == '0 ? '0 : (i_wb_reg_write && i_wb_write_sel == rt) ? i_wb_write_data : i_data_read_reg_1;

    assign o_stall = i_ex_mem_read && i_ex_rt != '0 && (i_ex_rt == rs || (ctrl.reads_rt && i_ex_rt == rt));
    assign imm_ext = ctrl.link ? i_pc_plus_4
                   : ctrl.ext == EXT_ZERO ? {16'b0, imm}
                   : ctrl.ext == EXT_LUI ? {imm, 16'b0}
                   : {{16{imm[15]}}, imm};
    assign dest = ctrl.link31 ? 5'd31 : ctrl.reg_dst ? rd : rt;
    assign branch_target = i_pc_plus_4 + {{14{imm[15]}}, imm, 2'b00};
    assign o_pc_next = ctrl.jump_reg ? rs_val
                     : ctrl.jump ? {i_pc_plus_4[31:28], i_instruction[25:0], 2'b00}
                     : branch_target;
    assign o_pc_source = i_valid && !i_flush && !o_stall && ctrl.valid
                       && (ctrl.jump || (ctrl.branch && ((rs_val == rt_val) != ctrl.branch_ne)));
    assign capture = ctrl.valid && !i_flush && !o_stall;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm_ext <= '0;
            o_rs <= '0;
            o_rt <= '0;
            o_rd_dest <= '0;
            o_shamt <= '0;
            o_alu_op <= '0;
            {o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg} <= '0;
        end else if (i_valid) begin
            o_rs_data <= capture ? rs_val : '0;
            o_rt_data <= capture ? rt_val : '0;
            o_imm_ext <= capture ? imm_ext : '0;
            o_rs <= capture ? rs : '0;
            o_rt <= capture ? rt : '0;
            o_rd_dest <= capture ? dest : '0;
            o_shamt <= capture ? i_instruction[10:6] : '0;
            o_alu_op <= capture ? ctrl.alu_op : '0;
            {o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg} <= capture
                ? {ctrl.alu_src, ctrl.mem_read, ctrl.mem_write, ctrl.reg_write, ctrl.mem_to_reg} : '0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against an instruction-level model
// (jump expectations follow MIPS_JUMP_EN).
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dest, shamt;
        logic [3:0]  alu;
        logic        src, mr, mw, rw, m2r;
    } idex_t;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid, i_flush, i_ex_mem_read, i_wb_reg_write;
    logic [31:0] i_instruction, i_pc_plus_4, i_wb_write_data, i_data_read_reg_0, i_data_read_reg_1;
    logic [4:0]  i_ex_rt, i_wb_write_sel, o_read_reg_sel_0, o_read_reg_sel_1;
    logic [4:0]  o_rs, o_rt, o_rd_dest, o_shamt;
    logic        o_stall, o_pc_source, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg;
    logic [31:0] o_pc_next, o_rs_data, o_rt_data, o_imm_ext;
    logic [3:0]  o_alu_op;
    logic [31:0] bank [32];
    logic [127:0] got, want;
    logic [5:0]  ops [18] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13,
                              6'd14, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'h3F};
    logic [5:0]  fns [14] = '{6'd33, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                              6'd0, 6'd2, 6'd3, 6'd8, 6'd9, 6'd1, 6'h3F};
    int total = 0;
    int bad = 0;

    always #5 i_clock = ~i_clock;
    assign i_data_read_reg_0 = bank[o_read_reg_sel_0];
    assign i_data_read_reg_1 = bank[o_read_reg_sel_1];

    decode_stage dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_instruction(i_instruction), .i_pc_plus_4(i_pc_plus_4), .i_flush(i_flush),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
        .i_wb_reg_write(i_wb_reg_write), .i_wb_write_sel(i_wb_write_sel), .i_wb_write_data(i_wb_write_data),
        .o_read_reg_sel_0(o_read_reg_sel_0), .o_read_reg_sel_1(o_read_reg_sel_1),
        .i_data_read_reg_0(i_data_read_reg_0), .i_data_read_reg_1(i_data_read_reg_1),
        .o_stall(o_stall), .o_pc_source(o_pc_source), .o_pc_next(o_pc_next),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd_dest(o_rd_dest), .o_shamt(o_shamt),
        .o_alu_op(o_alu_op), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg)
    );

    function automatic idex_t actual();
        return {o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd_dest, o_shamt,
                o_alu_op, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg};
    endfunction

    // care bits: {imm, dest, alu, alu_src, shamt}; fields the instruction leaves unspecified are zeroed
    function automatic idex_t mask(input idex_t v, input logic [4:0] c);
        if (!c[4]) v.imm = '0;
        if (!c[3]) v.dest = '0;
        if (!c[2]) v.alu = '0;
        if (!c[1]) v.src = '0;
        if (!c[0]) v.shamt = '0;
        return v;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] sel);
        if (sel == 5'd0) return 32'd0;
        if (i_wb_reg_write && i_wb_write_sel == sel) return i_wb_write_data;
        return bank[sel];
    endfunction

    function automatic void model(input logic [31:0] ins, pc4, a, b, output idex_t e, output logic [4:0] care,
                                  output logic ok, redir, uses_rt, output logic [31:0] target);
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [15:0] im = ins[15:0];
        logic [31:0] sx = {{16{im[15]}}, im};
        e = '0;
        care = 5'b11110;
        ok = 1'b1;
        redir = 1'b0;
        target = pc4 + (sx << 2);
        uses_rt = op == 6'd0 || op == 6'd43 || op == 6'd4 || op == 6'd5;
        e.rs_data = a;
        e.rt_data = b;
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        e.dest = ins[20:16];
        e.shamt = ins[10:6];
        e.imm = sx;
        e.rw = 1'b1;
        case (op)
            6'd0: begin
                e.dest = ins[15:11];
                care = 5'b01111;
                case (fn)
                    6'd33: e.alu = ALU_ADD;
                    6'd35: e.alu = ALU_SUB;
                    6'd36: e.alu = ALU_AND;
                    6'd37: e.alu = ALU_OR;
                    6'd38: e.alu = ALU_XOR;
                    6'd39: e.alu = ALU_NOR;
                    6'd42: e.alu = ALU_SLT;
                    6'd0:  e.alu = ALU_SLL;
                    6'd2:  e.alu = ALU_SRL;
                    6'd3:  e.alu = ALU_SRA;
`ifdef MIPS_JUMP_EN
                    6'd8: begin e.rw = 1'b0; care = 5'b00000; redir = 1'b1; target = a; end
                    6'd9: begin e.alu = ALU_PASS; e.imm = pc4; care = 5'b11100; redir = 1'b1; target = a; end
`endif
                    default: ok = 1'b0;
                endcase
            end
            6'd8, 6'd9: begin e.alu = ALU_ADD; e.src = 1'b1; end
            6'd10: begin e.alu = ALU_SLT; e.src = 1'b1; end
            6'd12: begin e.alu = ALU_AND; e.src = 1'b1; e.imm = {16'd0, im}; end
            6'd13: begin e.alu = ALU_OR; e.src = 1'b1; e.imm = {16'd0, im}; end
            6'd14: begin e.alu = ALU_XOR; e.src = 1'b1; e.imm = {16'd0, im}; end
            6'd15: begin e.alu = ALU_LUI; e.src = 1'b1; e.imm = {im, 16'd0}; end
            6'd35: begin e.alu = ALU_ADD; e.src = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; end
            6'd43: begin e.alu = ALU_ADD; e.src = 1'b1; e.mw = 1'b1; e.rw = 1'b0; care = 5'b10110; end
            6'd4: begin e.rw = 1'b0; care = 5'b00000; redir = a == b; end
            6'd5: begin e.rw = 1'b0; care = 5'b00000; redir = a != b; end
`ifdef MIPS_JUMP_EN
            6'd2: begin e.rw = 1'b0; care = 5'b00000; redir = 1'b1; target = {pc4[31:28], ins[25:0], 2'b00}; end
            6'd3: begin
                e.alu = ALU_PASS; e.imm = pc4; e.dest = 5'd31; care = 5'b11100;
                redir = 1'b1; target = {pc4[31:28], ins[25:0], 2'b00};
            end
`endif
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            care = 5'b11111;
            redir = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 17)];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        if (ins[31:26] == 6'd0) begin
            ins[15:11] = 5'($urandom_range(0, 7));
            ins[5:0] = fns[$urandom_range(0, 13)];
        end
        return ins;
    endfunction

    task automatic idle();
        i_reset = 1'b0;
        i_valid = 1'b1;
        i_flush = 1'b0;
        i_ex_mem_read = 1'b0;
        i_ex_rt = 5'd0;
        i_wb_reg_write = 1'b0;
        i_wb_write_sel = 5'd0;
        i_wb_write_data = 32'd0;
        i_instruction = 32'd0;
        i_pc_plus_4 = 32'd0;
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        i_instruction = 32'h00221821;
        i_reset = 1'b1;
        tick();
        total++;
        if (actual() !== idex_t'(0)) begin bad++; $display("FAIL reset got=%h exp=0", actual()); end
        i_reset = 1'b0;
    endtask

    task automatic test_addu();
        idle();
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        i_instruction = 32'h00221821;
        tick();
        got = {o_rs_data, o_rt_data, o_rd_dest, o_reg_write, o_alu_op, o_alu_src};
        want = {32'd5, 32'd7, 5'd3, 1'b1, ALU_ADD, 1'b0};
        total++;
        if (got !== want) begin bad++; $display("FAIL addu got=%h exp=%h", got, want); end
    endtask

    task automatic test_imm_ext();
        idle();
        i_instruction = 32'h2005FFFF;
        tick();
        got = {o_imm_ext, o_rd_dest, o_alu_src, o_reg_write};
        want = {32'hFFFFFFFF, 5'd5, 1'b1, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL addi_sext got=%h exp=%h", got, want); end
        i_instruction = 32'h3005FFFF;
        tick();
        got = {o_imm_ext, o_rd_dest, o_alu_src, o_reg_write};
        want = {32'h0000FFFF, 5'd5, 1'b1, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL andi_zext got=%h exp=%h", got, want); end
    endtask

    task automatic test_load_use();
        idle();
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        i_instruction = 32'h00221821;
        i_ex_mem_read = 1'b1;
        i_ex_rt = 5'd2;
        #1;
        total++;
        if (o_stall !== 1'b1) begin bad++; $display("FAIL stall_rt got=%b exp=1", o_stall); end
        tick();
        total++;
        if (actual() !== idex_t'(0)) begin bad++; $display("FAIL stall_bubble got=%h exp=0", actual()); end
        i_ex_mem_read = 1'b0;
        #1;
        total++;
        if (o_stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", o_stall); end
        tick();
        got = {o_rd_dest, o_reg_write, o_rs_data};
        want = {5'd3, 1'b1, 32'd5};
        total++;
        if (got !== want) begin bad++; $display("FAIL stall_resume got=%h exp=%h", got, want); end
        i_instruction = 32'h3005FFFF;
        i_ex_mem_read = 1'b1;
        i_ex_rt = 5'd5;
        #1;
        total++;
        if (o_stall !== 1'b0) begin bad++; $display("FAIL stall_itype_rt got=%b exp=0", o_stall); end
        i_instruction = 32'h30A5FFFF;
        #1;
        total++;
        if (o_stall !== 1'b1) begin bad++; $display("FAIL stall_rs got=%b exp=1", o_stall); end
        i_instruction = 32'h00001821;
        i_ex_rt = 5'd0;
        #1;
        total++;
        if (o_stall !== 1'b0) begin bad++; $display("FAIL stall_r0 got=%b exp=0", o_stall); end
    endtask

    task automatic test_branch();
        idle();
        bank[1] = 32'd9;
        bank[2] = 32'd9;
        i_pc_plus_4 = 32'h100;
        i_instruction = 32'h10220003;
        #1;
        got = {o_pc_source, o_pc_next};
        want = {1'b1, 32'h10C};
        total++;
        if (got !== want) begin bad++; $display("FAIL beq_taken got=%h exp=%h", got, want); end
        bank[2] = 32'd8;
        #1;
        total++;
        if (o_pc_source !== 1'b0) begin bad++; $display("FAIL beq_not_taken got=%b exp=0", o_pc_source); end
        i_instruction = 32'h14220003;
        #1;
        got = {o_pc_source, o_pc_next};
        total++;
        if (got !== want) begin bad++; $display("FAIL bne_taken got=%h exp=%h", got, want); end
        i_flush = 1'b1;
        #1;
        total++;
        if (o_pc_source !== 1'b0) begin bad++; $display("FAIL branch_flush got=%b exp=0", o_pc_source); end
        i_flush = 1'b0;
        i_pc_plus_4 = 32'd0;
        i_instruction = 32'h1000FFFF;
        #1;
        got = {o_pc_source, o_pc_next};
        want = {1'b1, 32'hFFFFFFFC};
        total++;
        if (got !== want) begin bad++; $display("FAIL beq_wrap got=%h exp=%h", got, want); end
    endtask

    task automatic test_bypass();
        idle();
        bank[1] = 32'd0;
        bank[2] = 32'd7;
        i_instruction = 32'h00221821;
        i_wb_reg_write = 1'b1;
        i_wb_write_sel = 5'd1;
        i_wb_write_data = 32'hDEADBEEF;
        tick();
        got = {o_rs_data, o_rt_data};
        want = {32'hDEADBEEF, 32'd7};
        total++;
        if (got !== want) begin bad++; $display("FAIL bypass_rs got=%h exp=%h", got, want); end
        bank[0] = 32'h55555555;
        i_instruction = 32'h00021821;
        i_wb_write_sel = 5'd0;
        i_wb_write_data = 32'h12345678;
        tick();
        total++;
        if (o_rs_data !== 32'd0) begin bad++; $display("FAIL bypass_r0 got=%h exp=0", o_rs_data); end
        bank[1] = 32'd9;
        bank[2] = 32'd8;
        i_pc_plus_4 = 32'h100;
        i_instruction = 32'h10220003;
        i_wb_write_sel = 5'd2;
        i_wb_write_data = 32'd9;
        #1;
        total++;
        if (o_pc_source !== 1'b1) begin bad++; $display("FAIL bypass_branch got=%b exp=1", o_pc_source); end
    endtask

    task automatic test_jump();
        idle();
        i_pc_plus_4 = 32'h100;
        i_instruction = 32'h08000040;
        #1;
`ifdef MIPS_JUMP_EN
        got = {o_pc_source, o_pc_next};
        want = {1'b1, 32'h100};
        total++;
        if (got !== want) begin bad++; $display("FAIL j_redirect got=%h exp=%h", got, want); end
        i_instruction = 32'h0C000040;
        tick();
        got = {o_rd_dest, o_reg_write, o_alu_op, o_imm_ext};
        want = {5'd31, 1'b1, ALU_PASS, 32'h100};
        total++;
        if (got !== want) begin bad++; $display("FAIL jal_link got=%h exp=%h", got, want); end
        bank[1] = 32'h2000;
        i_instruction = 32'h00200008;
        #1;
        got = {o_pc_source, o_pc_next};
        want = {1'b1, 32'h2000};
        total++;
        if (got !== want) begin bad++; $display("FAIL jr_redirect got=%h exp=%h", got, want); end
`else
        total++;
        if (o_pc_source !== 1'b0) begin bad++; $display("FAIL j_disabled got=%b exp=0", o_pc_source); end
        tick();
        total++;
        if (actual() !== idex_t'(0)) begin bad++; $display("FAIL j_bubble got=%h exp=0", actual()); end
`endif
    endtask

    task automatic test_hold_flush();
        idle();
        i_instruction = 32'h2005FFFF;
        tick();
        bank[1] = 32'd9;
        bank[2] = 32'd9;
        i_valid = 1'b0;
        i_flush = 1'b1;
        i_instruction = 32'h10220003;
        #1;
        total++;
        if (o_pc_source !== 1'b0) begin bad++; $display("FAIL hold_no_redirect got=%b exp=0", o_pc_source); end
        tick();
        got = {o_imm_ext, o_rd_dest, o_reg_write, o_alu_src};
        want = {32'hFFFFFFFF, 5'd5, 1'b1, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL hold got=%h exp=%h", got, want); end
        i_valid = 1'b1;
        i_instruction = 32'h00221821;
        tick();
        total++;
        if (actual() !== idex_t'(0)) begin bad++; $display("FAIL flush got=%h exp=0", actual()); end
    endtask

    task automatic test_reset_mid();
        idle();
        i_instruction = 32'h00221821;
        tick();
        i_reset = 1'b1;
        tick();
        total++;
        if (actual() !== idex_t'(0)) begin bad++; $display("FAIL reset_mid got=%h exp=0", actual()); end
        i_reset = 1'b0;
    endtask

    task automatic test_random();
        idex_t       e, exp_q;
        logic [4:0]  care, care_q;
        logic        ok, redir, uses_rt, stall_x, pcs_x;
        logic [31:0] a, b, target;
        idle();
        i_reset = 1'b1;
        tick();
        exp_q = '0;
        care_q = 5'b11111;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)
                for (int r = 0; r < 8; r++) bank[r] = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            i_reset = $urandom_range(0, 49) == 0;
            i_instruction = rand_instr();
            i_pc_plus_4 = $urandom & 32'hFFFFFFFC;
            i_valid = $urandom_range(0, 9) != 0;
            i_flush = $urandom_range(0, 9) == 0;
            i_ex_mem_read = $urandom_range(0, 2) == 0;
            i_ex_rt = 5'($urandom_range(0, 7));
            i_wb_reg_write = 1'($urandom_range(0, 1));
            i_wb_write_sel = 5'($urandom_range(0, 7));
            i_wb_write_data = $urandom;
            a = operand(i_instruction[25:21]);
            b = operand(i_instruction[20:16]);
            model(i_instruction, i_pc_plus_4, a, b, e, care, ok, redir, uses_rt, target);
            stall_x = i_ex_mem_read && i_ex_rt != 0
                      && (i_ex_rt == i_instruction[25:21] || (uses_rt && i_ex_rt == i_instruction[20:16]));
            pcs_x = i_valid && !i_flush && !stall_x && redir;
            #1;
            got = {o_read_reg_sel_0, o_read_reg_sel_1, o_stall, o_pc_source};
            want = {i_instruction[25:21], i_instruction[20:16], stall_x, pcs_x};
            total++;
            if (got !== want) begin bad++; $display("FAIL rand_comb n=%0d ins=%h got=%h exp=%h", n, i_instruction, got, want); end
            if (pcs_x) begin
                total++;
                if (o_pc_next !== target) begin bad++; $display("FAIL rand_pc_next n=%0d ins=%h got=%h exp=%h", n, i_instruction, o_pc_next, target); end
            end
            @(posedge i_clock);
            if (i_reset) begin
                exp_q = '0;
                care_q = 5'b11111;
            end else if (i_valid) begin
                exp_q = (i_flush || stall_x) ? '0 : e;
                care_q = (i_flush || stall_x) ? 5'b11111 : care;
            end
            #1;
            total++;
            if (mask(actual(), care_q) !== mask(exp_q, care_q)) begin
                bad++;
                $display("FAIL rand_idex n=%0d ins=%h got=%h exp=%h", n, i_instruction, mask(actual(), care_q), mask(exp_q, care_q));
            end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) bank[r] = 32'h100 + r;
        bank[0] = 32'hA5A5A5A5;
        test_reset();
        test_addu();
        test_imm_ext();
        test_load_use();
        test_branch();
        test_bypass();
        test_jump();
        test_hold_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the MIPS pipeline, between fetch (IF/ID) and execute (ID/EX). Drives the register bank read selects and captures the read data with a write-back bypass. Decodes opcode/funct into control signals and sign/zero-extends immediates. Resolves BEQ/BNE in decode, detects load-use hazards, and registers everything into the ID/EX pipeline register.

## Interface
- NB_DATA, 32, data/PC width
- NB_REGISTER, 5, register index width
- NB_ALU_OP, 4, ALU operation code width
- i_clock  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  pipeline advance enable; 0 freezes all state
- i_instruction  in  32  from IF/ID
- i_pc_plus_4  in  32  from IF/ID
- i_flush  in  1  replace current instruction with bubble
- i_ex_mem_read, i_ex_rt  in  1/5  EX-stage load flag and destination
- i_wb_reg_write, i_wb_write_sel, i_wb_write_data  in  1/5/32  write-back port (same as register bank write)
- o_read_reg_sel_0, o_read_reg_sel_1  out  5  to register bank (rs, rt), combinational
- i_data_read_reg_0, i_data_read_reg_1  in  32  from register bank, combinational
- o_stall  out  1  hold PC and IF/ID, combinational
- o_pc_source, o_pc_next  out  1/32  branch/jump redirect to fetch, combinational
- o_rs_data, o_rt_data, o_imm_ext  out  32  ID/EX, registered
- o_rs, o_rt, o_rd_dest, o_shamt  out  5  ID/EX, registered
- o_alu_op  out  4; o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg  out  1  ID/EX, registered

## Operation
- Selects: sel_0 = instr[25:21], sel_1 = instr[20:16].
- Bypass: if i_wb_reg_write, i_wb_write_sel != 0 and it equals a select, use i_wb_write_data for that operand. Register 0 always reads 0.
- Supported instructions:
  - R-type ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA.
  - ADDI, ADDIU, SLTI (sign-extend).
  - ANDI, ORI, XORI (zero-extend).
  - LUI (imm<<16).
  - LW, SW (sign-extend).
  - BEQ, BNE.
  - Any other opcode/funct decodes as a bubble.
- Destination: R-type uses rd; I-type uses rt; SW/branches set o_reg_write=0.
- Load-use stall: o_stall=1 when i_ex_mem_read, i_ex_rt != 0, and i_ex_rt equals rs, or equals rt for an instruction that reads rt (R-type, SW, BEQ, BNE). While stalled, ID/EX captures a bubble.
- Branch: BEQ/BNE compare bypassed operands. If taken: o_pc_source=1 and o_pc_next = i_pc_plus_4 + (sign-extended imm << 2), 32-bit wrap.
- Bubble: all control outputs 0 and o_rd_dest=0. Data fields are don't-care; they are driven 0.
- Priority on each edge: i_reset > !i_valid (hold) > i_flush (bubble) > o_stall (bubble) > normal capture.
- o_pc_source is forced 0 when o_stall, i_flush, or !i_valid.

## Timing
- One cycle of latency: the instruction present at edge N appears on the ID/EX outputs after edge N.
- o_stall, o_pc_source, o_pc_next and the read selects are combinational in the same cycle.
- Reset: every registered output is 0, i.e. a bubble, on the first edge with i_reset=1.
- Reset mid-operation discards the in-flight instruction.
- Stall lasts exactly one cycle per load-use pair; a second edge re-evaluates with the updated EX state.
- Write-back to the same register in the same cycle is resolved by the bypass, with no extra cycle.

## Configuration
- MIPS_JUMP_EN defined: decode J, JAL, JR and JALR.
  - J/JAL: o_pc_source=1, o_pc_next = {i_pc_plus_4[31:28], index, 2'b00}.
  - JR/JALR: o_pc_next = bypassed rs. JR is subject to load-use stall on rs.
  - JAL: o_rd_dest=31. JALR: o_rd_dest=rd. Both set o_reg_write=1, o_alu_op=PASS and o_imm_ext = i_pc_plus_4, so the link value flows to EX.
- MIPS_JUMP_EN undefined: these opcodes/functs decode as a bubble with no redirect.

## Structure
- Shared header/package holds:
  - opcode and funct localparams;
  - the ALU op encoding (ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, LUI, PASS);
  - NB_* widths, reused by execute.
- Sub-module control_unit: combinational opcode/funct to control bits, alu_op, extension mode and "reads rt" flag.
- Hazard detection, bypass, branch compare and the ID/EX register live in decode_stage.

## Test plan
- ADDU r3,r1,r2 (0x00221821), bank r1=5, r2=7 -> next cycle: o_rs_data=5, o_rt_data=7, o_rd_dest=3, o_reg_write=1, o_alu_op=ADD, o_alu_src=0.
- ADDI r5,r0,-1 (0x2005FFFF) -> o_imm_ext=0xFFFFFFFF. ANDI r5,r0,0xFFFF (0x3005FFFF) -> o_imm_ext=0x0000FFFF, o_rd_dest=5.
- EX holds LW r2 (i_ex_mem_read=1, i_ex_rt=2), decode holds 0x00221821 -> o_stall=1 and ID/EX is a bubble. Next cycle with i_ex_mem_read=0 -> normal capture.
- BEQ r1,r2,+3 (0x10220003), r1=r2=9, pc_plus_4=0x100 -> o_pc_source=1, o_pc_next=0x10C. With r2=8 -> o_pc_source=0.
- Bypass: bank r1=0 while WB writes r1=0xDEADBEEF the same cycle -> o_rs_data=0xDEADBEEF. WB write to r0 is ignored.
- MIPS_JUMP_EN: J (0x08000040), pc_plus_4=0x100 -> o_pc_next=0x100, o_pc_source=1. Without the macro -> bubble, o_pc_source=0. i_reset mid-stream -> all outputs 0.
